// File: rtl/reg_share_arbiter.sv
// ============================================================================
// Module  : reg_share_arbiter
// Purpose : Two-requester arbiter that guards one shared WIDTH-bit register.
//           Moore FSM (IDLE/G0/G1) with last-served tie-break and bounded hold.
//           Optional ARB_PARITY_EN adds a registered even-parity output q_par.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] wd0,
    input  logic [WIDTH-1:0] wd1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] q
`ifdef ARB_PARITY_EN
    ,
    output logic             q_par
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_G0   = 2'd1;
    localparam logic [1:0] S_G1   = 2'd2;

    localparam logic [3:0] C_HOLD_LAST = 4'(HOLD - 1);
    localparam logic [3:0] C_CNT_MAX   = 4'd15;

    logic [1:0]       state_q, state_d;
    logic             lp_q, lp_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             wr_en;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lp_d    = lp_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req0 && !req1) begin
                    state_d = S_G0;
                end else if (req1 && !req0) begin
                    state_d = S_G1;
                end else if (req0 && req1) begin
                    state_d = lp_q ? S_G0 : S_G1;
                end
            end

            S_G0: begin
                if (!req0) begin
                    state_d = req1 ? S_G1 : S_IDLE;
                end else if (req1 && (cnt_q == C_HOLD_LAST)) begin
                    state_d = S_G1;
                end else if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_G1: begin
                if (!req1) begin
                    state_d = req0 ? S_G0 : S_IDLE;
                end else if (req0 && (cnt_q == C_HOLD_LAST)) begin
                    state_d = S_G0;
                end else if (cnt_q != C_CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any transition into a grant state records the winner and restarts hold.
        if ((state_d == S_G0) && (state_q != S_G0)) begin
            lp_d  = 1'b0;
            cnt_d = 4'd0;
        end else if ((state_d == S_G1) && (state_q != S_G1)) begin
            lp_d  = 1'b1;
            cnt_d = 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Shared register write path: only the current holder may write,
    // including on the edge where its grant is handed over.
    // ------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        wr_en  = 1'b0;
        if ((state_q == S_G0) && we0) begin
            data_d = wd0;
            wr_en  = 1'b1;
        end else if ((state_q == S_G1) && we1) begin
            data_d = wd1;
            wr_en  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lp_q    <= 1'b1;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            lp_q    <= lp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
        end else if (wr_en) begin
            data_q <= data_d;
        end
    end

`ifdef ARB_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q <= 1'b0;
        end else if (wr_en) begin
            par_q <= ^data_d;
        end
    end

    assign q_par = par_q;
`endif

    assign gnt0 = (state_q == S_G0);
    assign gnt1 = (state_q == S_G1);
    assign busy = gnt0 | gnt1;
    assign q    = data_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
// ============================================================================
// Module  : tb_reg_share_arbiter
// Purpose : Scoreboard bench for reg_share_arbiter (HOLD=4 main, HOLD=1 aux).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_share_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] wd0, wd1;
    logic       gnt0, gnt1, busy;
    logic [7:0] q;
    logic       h_gnt0, h_gnt1, h_busy;
    logic [7:0] h_q;
`ifdef ARB_PARITY_EN
    logic       q_par;
    logic       h_q_par;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int h1_n     = 0;
    int step_id  = 0;

    typedef struct {
        int         id;
        logic       g0;
        logic       g1;
        logic [7:0] q;
        logic       h0;
        logic       h1;
    } exp_t;

    exp_t sb[$];

    reg_share_arbiter #(.WIDTH(8), .HOLD(4)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .we0  (we0),
        .we1  (we1),
        .wd0  (wd0),
        .wd1  (wd1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .busy (busy),
        .q    (q)
`ifdef ARB_PARITY_EN
        ,
        .q_par(q_par)
`endif
    );

    // Both requesters permanently asserted: must alternate every cycle.
    reg_share_arbiter #(.WIDTH(8), .HOLD(1)) u_dut_h1 (
        .clk  (clk),
        .rst  (rst),
        .req0 (1'b1),
        .req1 (1'b1),
        .we0  (1'b0),
        .we1  (1'b0),
        .wd0  (8'h00),
        .wd1  (8'h00),
        .gnt0 (h_gnt0),
        .gnt1 (h_gnt1),
        .busy (h_busy),
        .q    (h_q)
`ifdef ARB_PARITY_EN
        ,
        .q_par(h_q_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step%0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int id);
        chk("rst_gnt0", id, 32'(gnt0), 32'd0);
        chk("rst_gnt1", id, 32'(gnt1), 32'd0);
        chk("rst_busy", id, 32'(busy), 32'd0);
        chk("rst_q", id, 32'(q), 32'd0);
        chk("rst_h1_busy", id, 32'(h_busy), 32'd0);
`ifdef ARB_PARITY_EN
        chk("rst_q_par", id, 32'(q_par), 32'd0);
`endif
    endtask

    // Called at posedge+2; expectation describes the outputs after the next edge.
    task automatic step(input logic r0, input logic r1, input logic w0, input logic w1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic eg0, input logic eg1, input logic [7:0] eq);
        exp_t e;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; wd0 = d0; wd1 = d1;
        step_id++;
        h1_n++;
        e.id = step_id;
        e.g0 = eg0;
        e.g1 = eg1;
        e.q  = eq;
        e.h0 = (h1_n % 2) == 1;
        e.h1 = (h1_n % 2) == 0;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gnt0", e.id, 32'(gnt0), 32'(e.g0));
                chk("gnt1", e.id, 32'(gnt1), 32'(e.g1));
                chk("busy", e.id, 32'(busy), 32'(e.g0 | e.g1));
                chk("q", e.id, 32'(q), 32'(e.q));
                chk("h1_gnt0", e.id, 32'(h_gnt0), 32'(e.h0));
                chk("h1_gnt1", e.id, 32'(h_gnt1), 32'(e.h1));
`ifdef ARB_PARITY_EN
                chk("q_par", e.id, 32'(q_par), 32'(^e.q));
`endif
            end
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; wd0 = 8'h00; wd1 = 8'h00;

        #3;
        chk_reset_outputs(0);
        @(posedge clk);
        #2;
        chk_reset_outputs(0);
        rst = 1'b1;
        h1_n = 0;

        // Contention, HOLD=4: four cycles each, starting with requester 0.
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0, 8'h00, 8'h00, ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, 8'h00);
        end

        // Sole requester keeps the grant indefinitely; write lands.
        step(1, 0, 1, 0, 8'hA5, 8'h00, 1, 0, 8'hA5);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, 0, 8'hA5, 8'h00, 1, 0, 8'hA5);
        end

        // Non-granted write ignored, then handover and write by requester 1.
        step(1, 0, 0, 1, 8'h00, 8'h3C, 1, 0, 8'hA5);
        step(0, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 8'hA5);
        step(0, 1, 0, 1, 8'h00, 8'h3C, 0, 1, 8'h3C);

        // Write on the handover edge completes; then to IDLE with a final write.
        step(1, 0, 0, 1, 8'h00, 8'h5A, 1, 0, 8'h5A);
        step(0, 0, 1, 0, 8'hFF, 8'h00, 0, 0, 8'hFF);
        step(0, 0, 1, 0, 8'h11, 8'h00, 0, 0, 8'hFF);

        // From IDLE: grant one edge later, write one edge after that.
        step(1, 0, 1, 0, 8'h07, 8'h00, 1, 0, 8'hFF);
        step(1, 0, 1, 0, 8'h07, 8'h00, 1, 0, 8'h07);
        step(1, 0, 1, 0, 8'h03, 8'h00, 1, 0, 8'h03);

        // Tie from IDLE goes to requester 1 since 0 was served last.
        step(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h03);
        step(1, 1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h03);

        // Asynchronous reset between edges while G1 has a write pending.
        req0 = 1'b0; req1 = 1'b1; we0 = 1'b0; we1 = 1'b1; wd1 = 8'h77;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs(100);
        @(posedge clk);
        #2;
        chk_reset_outputs(101);
        rst = 1'b1;
        h1_n = 0;

        step(0, 1, 0, 1, 8'h00, 8'h77, 0, 1, 8'h00);
        step(0, 1, 0, 1, 8'h00, 8'h77, 0, 1, 8'h77);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #3;
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_share_arbiter.md
REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, width of the shared register and of both write-data ports.
REQ-002 Parameter HOLD, default 4, maximum consecutive grant cycles when the other requester is waiting; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  access request from requester 0 / 1.
REQ-006 we0, we1  input  1 each  write enable from requester 0 / 1.
REQ-007 wd0, wd1  input  WIDTH each  write data from requester 0 / 1.
REQ-008 gnt0, gnt1  output  1 each  grant to requester 0 / 1; never both high.
REQ-009 q  output  WIDTH  contents of the shared register.
REQ-010 busy  output  1  high whenever either grant is high.

Function
REQ-011 The block SHALL implement a Moore FSM with states IDLE, G0, G1; gnt0 = (state==G0), gnt1 = (state==G1), busy = gnt0|gnt1, all decoded from registered state.
REQ-012 IDLE: req0 only -> G0; req1 only -> G1; both -> the requester not recorded in last-served pointer lp; neither -> IDLE.
REQ-013 Grant therefore appears exactly one clock after a request is first sampled in IDLE.
REQ-014 On every entry to Gx, lp SHALL be set to x and the hold counter cnt (4 bits) cleared to 0.
REQ-015 In Gx with reqx low: -> G(other) if req_other high, else -> IDLE (no dead cycle on handover).
REQ-016 In Gx with reqx high, req_other high and cnt==HOLD-1: -> G(other) (forced rotation).
REQ-017 Otherwise in Gx: stay; cnt increments, saturating at 15.
REQ-018 With req_other low the holder SHALL keep the grant indefinitely regardless of cnt.
REQ-019 Write: at a rising edge with state==Gx and wex high, q SHALL load wdx; new value visible after that edge.
REQ-020 we/wd from the non-granted requester, and any write in IDLE, SHALL be ignored; q holds.
REQ-021 A write in the last cycle of a grant (same edge as handover) SHALL complete.
REQ-022 HOLD=1: with both requesting continuously, the grant alternates every cycle.

Reset
REQ-023 rst low SHALL immediately, without clk, force state=IDLE, gnt0=gnt1=0, busy=0, q=0, cnt=0, lp=1 (so requester 0 wins the first tie).
REQ-024 Reset asserted mid-grant SHALL abort the grant and discard any write pending on that edge.
REQ-025 After rst rises, the first rising edge SHALL be evaluated as from IDLE.

Configuration
REQ-026 Macro ARB_PARITY_EN: when defined, the block SHALL add output q_par (1 bit) = even parity (XOR reduction) of q, registered with q, reset to 0.
REQ-027 When ARB_PARITY_EN is undefined, port q_par and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset: rst=0 at t=0 with req0=req1=1 -> gnt0=gnt1=0, q=0 until rst rises; first edge after -> gnt0=1.
REQ-029 Single requester: req0=1, we0=1, wd0=8'hA5 for 3 cycles -> gnt0 high from cycle 2, q=8'hA5 one edge after gnt0 rises; gnt1 stays 0.
REQ-030 Contention (HOLD=4): req0, req1 both held high -> gnt0 4 cycles, gnt1 4 cycles, alternating, never overlapping, no idle gap.
REQ-031 Ignored write: gnt0 high, we1=1, wd1=8'h3C -> q unchanged; then req0 drops -> gnt1 next edge, we1 write lands q=8'h3C.
REQ-032 Async reset mid-grant: during G1 with we1=1, pull rst low between edges -> gnt1 drops immediately, q=0, no write on following edge.
REQ-033 ARB_PARITY_EN defined: write 8'h07 -> q_par=1; write 8'h03 -> q_par=0.
